// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Brief    : Two-requester arbiter in front of one shared combinational ALU,
//            with registered per-lane responses. Define ALU_ARB_FIXED_PRIO_EN
//            for fixed priority (lane 0 wins) instead of round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
  parameter logic [5:0] IDLE_OP = 6'd28
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [63:0] req_inputA,
  input  logic [63:0] req_inputB,
  input  logic [11:0] req_aluOP,
  output logic [31:0] alu_inputA,
  output logic [31:0] alu_inputB,
  output logic [5:0]  alu_aluOP,
  input  logic [31:0] alu_result,
  input  logic        alu_negative,
  input  logic        alu_zero,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [63:0] rsp_result,
  output logic [1:0]  rsp_negative,
  output logic [1:0]  rsp_zero,
  output logic [1:0]  rsp_err
);

  localparam int unsigned c_LANES      = 2;
  localparam logic [5:0]  c_ERR_OP_MIN = 6'd38;

  logic [31:0] w_lane_a  [c_LANES];
  logic [31:0] w_lane_b  [c_LANES];
  logic [5:0]  w_lane_op [c_LANES];

  logic [1:0]  w_elig;
  logic [1:0]  w_gnt;
  logic        w_gnt_idx;
  logic        w_any_gnt;
  logic        w_illegal;
  logic [31:0] w_cap_result;
  logic        w_cap_neg;
  logic        w_cap_zero;

  logic [1:0]  rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_result_q [c_LANES];
  logic [1:0]  rsp_neg_q;
  logic [1:0]  rsp_zero_q;
  logic [1:0]  rsp_err_q;

  // A lane may be granted while its old response drains in the same cycle.
  always_comb begin
    w_elig = req_valid & (~rsp_valid_q | rsp_ready) & {2{~rst}};
  end

`ifdef ALU_ARB_FIXED_PRIO_EN
  always_comb begin
    w_gnt = 2'b00;
    if (w_elig[0]) begin
      w_gnt = 2'b01;
    end else if (w_elig[1]) begin
      w_gnt = 2'b10;
    end
  end
`else
  logic last_q, last_d;

  // last_q names the lane granted most recently; the other lane wins a tie.
  always_comb begin
    w_gnt = w_elig;
    if (&w_elig) begin
      w_gnt = last_q ? 2'b01 : 2'b10;
    end
  end

  always_comb begin
    last_d = last_q;
    if (w_gnt[1]) begin
      last_d = 1'b1;
    end else if (w_gnt[0]) begin
      last_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  assign req_ready = w_gnt;
  assign w_gnt_idx = w_gnt[1];
  assign w_any_gnt = |w_gnt;

  always_comb begin
    alu_inputA = 32'd0;
    alu_inputB = 32'd0;
    alu_aluOP  = IDLE_OP;
    if (w_any_gnt) begin
      alu_inputA = w_lane_a[w_gnt_idx];
      alu_inputB = w_lane_b[w_gnt_idx];
      alu_aluOP  = w_lane_op[w_gnt_idx];
    end
  end

  // Illegal opcodes still complete, but report a clean zero result.
  always_comb begin
    w_illegal    = w_any_gnt && (w_lane_op[w_gnt_idx] >= c_ERR_OP_MIN);
    w_cap_result = w_illegal ? 32'd0 : alu_result;
    w_cap_neg    = w_illegal ? 1'b0  : alu_negative;
    w_cap_zero   = w_illegal ? 1'b1  : alu_zero;
  end

  genvar gi;
  generate
    for (gi = 0; gi < c_LANES; gi++) begin : g_lane
      assign w_lane_a[gi]  = req_inputA[32*gi +: 32];
      assign w_lane_b[gi]  = req_inputB[32*gi +: 32];
      assign w_lane_op[gi] = req_aluOP[6*gi +: 6];

      always_comb begin
        rsp_valid_d[gi] = w_gnt[gi] | (rsp_valid_q[gi] & ~rsp_ready[gi]);
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          rsp_valid_q[gi]  <= 1'b0;
          rsp_result_q[gi] <= 32'd0;
          rsp_neg_q[gi]    <= 1'b0;
          rsp_zero_q[gi]   <= 1'b0;
          rsp_err_q[gi]    <= 1'b0;
        end else begin
          rsp_valid_q[gi] <= rsp_valid_d[gi];
          if (w_gnt[gi]) begin
            rsp_result_q[gi] <= w_cap_result;
            rsp_neg_q[gi]    <= w_cap_neg;
            rsp_zero_q[gi]   <= w_cap_zero;
            rsp_err_q[gi]    <= w_illegal;
          end
        end
      end

      assign rsp_result[32*gi +: 32] = rsp_result_q[gi];
    end
  endgenerate

  assign rsp_valid    = rsp_valid_q;
  assign rsp_negative = rsp_neg_q;
  assign rsp_zero     = rsp_zero_q;
  assign rsp_err      = rsp_err_q;

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter IDLE_OP, default 6'd28 (CU_ADD), aluOP driven to the ALU when no request is granted.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port req_valid  input  2  per-requester request valid; lane i = requester i.
REQ-005 SHALL have port req_ready  output  2  per-requester accept; a request transfers when valid & ready.
REQ-006 SHALL have port req_inputA  input  64  operand A, lane i at bits [32i+31:32i].
REQ-007 SHALL have port req_inputB  input  64  operand B, same packing.
REQ-008 SHALL have port req_aluOP  input  12  cuOPType opcode, lane i at bits [6i+5:6i].
REQ-009 SHALL have port alu_inputA  output  32  operand A to the shared alu.
REQ-010 SHALL have port alu_inputB  output  32  operand B to the shared alu.
REQ-011 SHALL have port alu_aluOP  output  6  opcode to the shared alu.
REQ-012 SHALL have port alu_result  input  32  ALUResult from the shared alu (combinational, same cycle).
REQ-013 SHALL have port alu_negative  input  1  negative flag from the alu.
REQ-014 SHALL have port alu_zero  input  1  zero flag from the alu.
REQ-015 SHALL have port rsp_valid  output  2  per-requester response valid.
REQ-016 SHALL have port rsp_ready  input  2  per-requester response accept.
REQ-017 SHALL have port rsp_result  output  64  registered result, lane packing as operands.
REQ-018 SHALL have port rsp_negative  output  2  registered negative flag per lane.
REQ-019 SHALL have port rsp_zero  output  2  registered zero flag per lane.
REQ-020 SHALL have port rsp_err  output  2  registered illegal-opcode flag per lane.

Function
REQ-021 SHALL grant at most one requester per cycle; req_ready is one-hot or zero.
REQ-022 SHALL treat lane i as eligible when req_valid[i] and (rsp_valid[i]==0 or rsp_ready[i]==1), i.e. drain-through in the same cycle is allowed.
REQ-023 SHALL arbitrate round-robin: with both eligible, the lane not granted most recently wins; last-grant pointer updates only on a grant.
REQ-024 SHALL drive alu_inputA/B/aluOP from the granted lane combinationally; with no grant, drive 0, 0, IDLE_OP.
REQ-025 SHALL capture alu_result, alu_negative, alu_zero into lane i response registers on the grant edge; rsp_valid[i]=1 exactly one cycle after the request handshake.
REQ-026 SHALL hold rsp_result/flags of lane i stable while rsp_valid[i] & ~rsp_ready[i].
REQ-027 SHALL clear rsp_valid[i] on rsp_ready[i] unless a new grant to lane i occurs the same cycle, in which case the new result replaces it with rsp_valid[i] staying 1.
REQ-028 SHALL, for aluOP >= 6'd38 (CU_ERROR and above), still complete the transaction but register result 0, negative 0, zero 1, rsp_err 1; otherwise rsp_err 0.
REQ-029 SHALL keep both lanes fully independent: a stalled response on one lane never blocks grants to the other.

Reset
REQ-030 SHALL on rst set rsp_valid=0, rsp_result=0, rsp_negative=0, rsp_zero=0, rsp_err=0, last-grant pointer=1 (lane 0 wins first).
REQ-031 SHALL force req_ready=0 and drive ALU idle values in any cycle with rst=1; a request presented during reset is not accepted.
REQ-032 SHALL discard any pending response when rst asserts mid-operation; rsp_valid=0 from the following cycle.

Configuration
REQ-033 SHALL, when ALU_ARB_FIXED_PRIO_EN is defined, use fixed priority (lane 0 always wins when both eligible) and omit the last-grant pointer; when undefined, use round-robin per REQ-023.

Verification
REQ-034 SHALL cover: lane 0 ADD 40+90 -> next cycle rsp_valid[0]=1, result 130, negative 0, zero 0.
REQ-035 SHALL cover: after reset both valid, lane 0 SUB 10-10, lane 1 SLL 256<<3 -> lane 0 granted first (zero=1), lane 1 granted next cycle (result 2048).
REQ-036 SHALL cover: lane 0 SUB -10-(-5) with rsp_ready[0]=0 -> result 0xFFFFFFFB held, req_ready[0]=0 for a new request until rsp_ready[0]=1, then drain-through accepts it that cycle.
REQ-037 SHALL cover: both lanes continuously valid, rsp_ready=2'b11 -> grants alternate 0,1,0,1 (round-robin) or lane 0 only (ALU_ARB_FIXED_PRIO_EN).
REQ-038 SHALL cover: lane 1 aluOP 6'd38 -> rsp_err[1]=1, result 0, zero 1; then rst asserted with rsp_valid[1]=1 -> rsp_valid=0 next cycle, no grant in the reset cycle.
